tube_scan_ctrl: RTL

//  Hardware scan sequencer for the 4-digit seven-segment display on the peripheral bus. It replaces the timer-ISR digit multiplexing loop.
//  - Software writes a 16-bit hex value once; the block decodes it and time-multiplexes the 4 digits onto DIGI.
//  - One blanking gap precedes each digit; a pulse marks each completed frame.
//  - Legacy raw writes to DIGI still work while scanning is disabled.

---
 rtl/tube_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 14 +
 rtl/tube_scan_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// Shared definitions for the seven-segment scan sequencer: FSM states,
// segment patterns and register layout.
package tube_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_BLANK = 2'd2,
      ST_SHOW  = 2'd3
   } state_t;

   // Active-low segment pattern with every segment dark
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low hex glyphs, entry n is the glyph for nibble n
   localparam logic [15:0][6:0] SEG_TAB = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Register offsets relative to the block base address
   localparam logic [31:0] VALUE_OFS = 32'h0000_0000;
   localparam logic [31:0] CTRL_OFS  = 32'h0000_0004;

   // CTRL bit positions
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_LZ_BIT    = 1;
   localparam int CTRL_FRAME_BIT = 8;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
   import tube_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Table lookup of the glyph for the selected nibble
   always_comb begin
      seg = SEG_TAB[nib];
   end

endmodule

// File: rtl/tube_scan_ctrl.sv
// Scan sequencer for the 4-digit seven-segment display. Software loads a
// 16-bit value; the block multiplexes the four digits onto digi with a
// blanking gap before each digit and pulses frame_irq per completed frame.
// With scanning disabled, the legacy raw DIGI register drives the display.
module tube_scan_ctrl
   import tube_pkg::*;
#(
   parameter int          DWELL_CYC = 50000,
   parameter int          BLANK_CYC = 16,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0024,
   parameter logic [31:0] DIGI_ADDR = 32'h4000_0014
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_wr,
   input  logic        mem_rd,
   output logic [31:0] rdata,
   output logic        rd_hit,
   output logic [10:0] digi,
   output logic        frame_irq
);

   // One counter serves both the blank and dwell phases; the dwell is the longer one
   localparam int                CNT_W      = $clog2(DWELL_CYC + 1);
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [31:0]       VALUE_ADDR = BASE_ADDR + VALUE_OFS;
   localparam logic [31:0]       CTRL_ADDR  = BASE_ADDR + CTRL_OFS;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        idx_q;
   logic [15:0]       value_q;
   logic [15:0]       shadow_q;
   logic              en_q;
   logic              lz_q;
   logic              frame_q;
   logic              irq_q;
   logic [10:0]       raw_q;

   logic              value_hit;
   logic              ctrl_hit;
   logic              digi_hit;
   logic              value_wr;
   logic              ctrl_wr;
   logic              digi_wr;
   logic              ctrl_rd;
   logic              disable_wr;
   logic              blank_end;
   logic              show_end;
   logic              frame_end;
   logic [3:0]        nib_sel;
   logic [6:0]        seg_dec;
   logic              hi_zero;
   logic [3:0]        an_sel;
   logic              unused_wdata;

   assign value_hit  = (addr == VALUE_ADDR);
   assign ctrl_hit   = (addr == CTRL_ADDR);
   assign digi_hit   = (addr == DIGI_ADDR);
   assign value_wr   = mem_wr & value_hit;
   assign ctrl_wr    = mem_wr & ctrl_hit;
   assign digi_wr    = mem_wr & digi_hit;
   assign ctrl_rd    = mem_rd & ctrl_hit;
   assign disable_wr = ctrl_wr & ~wdata[CTRL_EN_BIT];

   assign blank_end  = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
   assign show_end   = (state_q == ST_SHOW) && (cnt_q == DWELL_LAST);
   assign frame_end  = show_end && (idx_q == 2'd3);

   assign rd_hit       = value_hit | ctrl_hit | digi_hit;
   assign frame_irq    = irq_q;
   assign unused_wdata = ^wdata[31:16];

   // Select the nibble of the latched value belonging to the current digit
   always_comb begin
      nib_sel = shadow_q[{idx_q, 2'b00} +: 4];
      hi_zero = ((shadow_q >> {idx_q, 2'b00}) == 16'h0000);
      an_sel  = 4'b0001 << idx_q;
   end

   hex_to_seg7 u_dec (
      .nib (nib_sel),
      .seg (seg_dec)
   );

   // Register file, frame flag, interrupt pulse and scan FSM with its counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= 16'h0000;
         en_q    <= 1'b0;
         lz_q    <= 1'b0;
         raw_q   <= {4'h0, SEG_BLANK};
         frame_q <= 1'b0;
         irq_q   <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
      end else begin
         if (value_wr) value_q <= wdata[15:0];
         if (ctrl_wr) begin
            en_q <= wdata[CTRL_EN_BIT];
            lz_q <= wdata[CTRL_LZ_BIT];
         end
         if (digi_wr) raw_q <= wdata[10:0];

         // A frame completing in the same cycle as a clearing read keeps FRAME set
         irq_q <= frame_end & ~disable_wr;
         if (frame_end && !disable_wr) frame_q <= 1'b1;
         else if (ctrl_rd)             frame_q <= 1'b0;

         if (disable_wr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q <= '0;
                  idx_q <= 2'd0;
                  if (en_q) state_q <= ST_LOAD;
               end
               ST_LOAD: begin
                  cnt_q   <= '0;
                  idx_q   <= 2'd0;
                  state_q <= ST_BLANK;
               end
               ST_BLANK: begin
                  if (blank_end) begin
                     cnt_q   <= '0;
                     state_q <= ST_SHOW;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_SHOW: begin
                  if (show_end) begin
                     cnt_q <= '0;
                     if (idx_q == 2'd3) begin
                        state_q <= ST_LOAD;
                     end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= ST_BLANK;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  idx_q   <= 2'd0;
               end
            endcase
         end
      end
   end

   // Latch the display value once per frame so mid-frame writes cannot tear it
   always_ff @(posedge clk) begin
      if (state_q == ST_LOAD) shadow_q <= value_q;
   end

   // Display mux: raw register when idle, dark during load/blank, glyph when shown
   always_comb begin
      digi = {4'h0, SEG_BLANK};
      case (state_q)
         ST_IDLE:  digi = raw_q;
         ST_LOAD:  digi = {4'h0, SEG_BLANK};
         ST_BLANK: digi = {4'h0, SEG_BLANK};
         ST_SHOW: begin
            if (lz_q && (idx_q != 2'd0) && hi_zero) digi = {4'h0, SEG_BLANK};
            else                                    digi = {an_sel, seg_dec};
         end
         default:  digi = {4'h0, SEG_BLANK};
      endcase
   end

   // Bus read mux; unmapped addresses read as zero
   always_comb begin
      rdata = 32'h0000_0000;
      if (value_hit)     rdata = {16'h0000, value_q};
      else if (ctrl_hit) rdata = {23'h0, frame_q, 6'h00, lz_q, en_q};
      else if (digi_hit) rdata = {21'h0, digi};
   end

endmodule
